tone_burst_osc: RTL and testbench
=================================

# tone_burst_osc

Event-driven square-wave tone generator for the game's audio path: each of NUM_EVENTS trigger inputs (wall hit, block hit, …) is mapped to its own pitch, and a rising edge on a trigger plays a fixed-length tone burst. A fixed priority arbitrates between events, and the block returns to silence on its own when the burst ends. Its 32-bit signed sample output feeds the audio codec sample path in place of the free-running oscillator.

## Interface
- NUM_EVENTS, 2: number of trigger inputs (≥1).
- HALF_PERIOD_W, 20: width of each half-period entry.
- HALF_PERIODS, {20'd31_250, 20'd56_818}: packed table, entry i at bits [i*HALF_PERIOD_W +: HALF_PERIOD_W], in CLOCK_50 cycles. Default: event 0 = 440 Hz, event 1 = 800 Hz.
- DURATION_CYCLES, 32'd5_000_000: burst length in cycles (100 ms).
- AMPLITUDE, 32'd100_000_000: peak sample magnitude.
- DECAY_SHIFT, 4: decay step shift. Used only with TONE_DECAY_EN.
- CLOCK_50  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- trigger  in  NUM_EVENTS  event requests; only rising edges matter.
- mute  in  1  forces out to 0; timers keep running.
- out  out  32  signed sample: +amp, −amp or 0.
- busy  out  1  high while a burst plays.
- active  out  NUM_EVENTS  one-hot index of the playing event; 0 when idle.

## Operation
- Edge detect: trig_q registers trigger each cycle. rise = trigger & ~trig_q. trig_q resets to 0, so a trigger held high through reset release fires on the first edge after release.
- FSM states: IDLE and PLAY.
- Priority: among simultaneous rises, the lowest index wins.
- IDLE → PLAY on any rise. Load:
  - sel = winning index;
  - half = HALF_PERIODS[sel], with 0 treated as 1;
  - count = 0; phase = 1;
  - remain = DURATION_CYCLES−1, with 0 treated as 1 (so remain = 0);
  - amp = AMPLITUDE.
- In PLAY, each edge with no reload:
  - if count == half−1: count ← 0 and phase toggles; otherwise count increments;
  - if remain == 0: go to IDLE; otherwise remain decrements.
- In PLAY, rises are handled in this order:
  - **Preempt:** a rise on an index lower than sel performs the full load above.
  - **Retrigger:** otherwise, a rise on sel reloads remain (and amp) only. count and phase continue, so there is no waveform glitch.
  - Rises on higher indices are ignored; they are not queued.
- Simultaneous events:
  - preempt beats retrigger;
  - retrigger or preempt beats expiry (remain == 0) and the block stays in PLAY.
- Outputs are decoded from registers plus mute:
  - out = 0 when IDLE or mute = 1; otherwise out = phase ? +amp : −amp (two's complement);
  - busy = (state == PLAY);
  - active = one-hot(sel) when busy, else 0.
- Widths: count is HALF_PERIOD_W bits and remain is 32 bits; neither can wrap, given the reload rules above.
- Reset (asynchronous, any time including mid-burst): state = IDLE, trig_q = 0, count = 0, phase = 0, remain = 0, sel = 0, amp = AMPLITUDE. Outputs become out = 0, busy = 0, active = 0 immediately, without waiting for a clock edge.

## Timing
- A rise sampled at edge k gives PLAY, busy = 1 and out = +amp right after edge k.
- The first phase toggle is at edge k+half, so each half-cycle is exactly `half` cycles.
- PLAY lasts exactly DURATION_CYCLES cycles. The block is back in IDLE right after edge k+DURATION_CYCLES, unless reloaded.
- mute acts combinationally, with no added latency.

## Configuration
- Macro TONE_DECAY_EN.
- **Defined:** on every phase toggle 0→1, amp ← amp − (amp >> DECAY_SHIFT), floored at 0. amp reloads to AMPLITUDE on start, preempt and retrigger.
- **Undefined:** amp stays at AMPLITUDE and no decay logic is built.

## Test plan
Parameters for all scenarios: NUM_EVENTS = 3, halves {10, 6, 4} (entries 0, 1, 2 = 4, 6, 10), DURATION_CYCLES = 40, AMPLITUDE = 1000.
- **Basic burst:** one pulse on trigger[1] at edge k → out = +1000 for 6 cycles, then −1000 for 6 cycles, repeating; busy = 1 and active = 3'b010 for exactly 40 cycles; out = 0 and busy = 0 after edge k+40.
- **Priority and preempt:** trigger[2] at k, then trigger[0] at k+5 → at k+5 active = 001, out = +1000 with period 8, and the burst ends at k+45. A trigger[2] edge at k+10 is ignored.
- **Retrigger and expiry:** trigger[1] at k, re-pulsed at k+39 (the expiry edge) → stays in PLAY with no phase discontinuity; busy falls after k+79.
- **Simultaneous rises and held input:** trigger = 3'b110 rising on one edge → active = 010. Holding trigger high produces no further retriggers.
- **Mute and reset:** mute = 1 mid-burst gives out = 0 while busy stays 1 and the end time is unchanged. Asserting reset asynchronously mid-burst makes out, busy and active = 0 before the next clock edge.
- **TONE_DECAY_EN:** peak values follow 1000, 938, 880, 825, … (one step per period). Without the macro, the peak stays 1000.

Source files
------------

// File: rtl/tone_burst_osc.sv
// Event-triggered square-wave tone burst generator with fixed-priority preempt and retrigger.
// Optional per-period amplitude decay is built when TONE_DECAY_EN is defined.
module tone_burst_osc #(
    parameter int                                  NUM_EVENTS      = 2,
    parameter int                                  HALF_PERIOD_W   = 20,
    parameter logic [NUM_EVENTS*HALF_PERIOD_W-1:0] HALF_PERIODS    = {20'd31_250, 20'd56_818},
    parameter logic [31:0]                         DURATION_CYCLES = 32'd5_000_000,
    parameter logic [31:0]                         AMPLITUDE       = 32'd100_000_000,
    parameter int                                  DECAY_SHIFT     = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] trigger,
    input  logic                  mute,
    output logic signed [31:0]    out,
    output logic                  busy,
    output logic [NUM_EVENTS-1:0] active
);

    localparam int          SEL_W       = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam logic [31:0] REMAIN_INIT = (DURATION_CYCLES == 32'd0) ? 32'd0 : DURATION_CYCLES - 32'd1;

    typedef enum logic {IDLE, PLAY} state_t;
    state_t state, state_nxt;

    logic [NUM_EVENTS-1:0]    trig_q, rise;
    logic [SEL_W-1:0]         sel, win;
    logic                     any_rise, load, retrig, wrap;
    logic [HALF_PERIOD_W-1:0] half, half_ld, count;
    logic                     phase;
    logic [31:0]              remain, amp;

    assign rise     = trigger & ~trig_q;
    assign any_rise = |rise;

    // Lowest index wins among simultaneous rises.
    always_comb begin
        win = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--)
            if (rise[i]) win = SEL_W'(i);
    end

    always_comb begin
        half_ld = HALF_PERIODS[int'(win)*HALF_PERIOD_W +: HALF_PERIOD_W];
        if (half_ld == '0) half_ld = HALF_PERIOD_W'(1);
    end

    assign load   = any_rise && (state == IDLE || win < sel);
    assign retrig = (state == PLAY) && !load && rise[sel];
    assign wrap   = (count == half - 1'b1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A reload on the expiry edge keeps the burst alive.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_rise) state_nxt = PLAY;
            PLAY: if (!load && !retrig && remain == 32'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            trig_q <= '0;
            sel    <= '0;
            half   <= '0;
            count  <= '0;
            phase  <= 1'b0;
            remain <= '0;
        end else begin
            trig_q <= trigger;
            if (load) begin
                sel    <= win;
                half   <= half_ld;
                count  <= '0;
                phase  <= 1'b1;
                remain <= REMAIN_INIT;
            end else if (state == PLAY) begin
                if (wrap) begin
                    count <= '0;
                    phase <= ~phase;
                end else begin
                    count <= count + 1'b1;
                end
                if (retrig)                remain <= REMAIN_INIT;
                else if (remain != 32'd0)  remain <= remain - 32'd1;
            end
        end
    end

`ifdef TONE_DECAY_EN
    // amp - (amp >> s) never goes below zero, so no explicit floor is needed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                              amp <= AMPLITUDE;
        else if (load || retrig)                amp <= AMPLITUDE;
        else if (state == PLAY && wrap && !phase) amp <= amp - (amp >> DECAY_SHIFT);
    end
`else
    logic unused_decay_shift;
    assign unused_decay_shift = (DECAY_SHIFT != 0);
    assign amp = AMPLITUDE;
`endif

    always_comb begin
        busy = (state == PLAY);
        for (int i = 0; i < NUM_EVENTS; i++)
            active[i] = busy && (sel == SEL_W'(i));
        if (busy && !mute) out = phase ? $signed(amp) : -$signed(amp);
        else               out = '0;
    end

endmodule

// File: tb/tb_tone_burst_osc.sv
// Directed bench for tone_burst_osc: a timeline model of bursts checked every cycle,
// plus hand-computed expectations at key edges of each scenario.
module tb_tone_burst_osc;

    localparam int DUR = 40;
    localparam int AMP = 1000;
    localparam int DS  = 4;

    logic               CLOCK_50 = 1'b0;
    logic               reset;
    logic [2:0]         trigger;
    logic               mute;
    logic signed [31:0] out;
    logic               busy;
    logic [2:0]         active;

    int errors = 0;
    int checks = 0;

    tone_burst_osc #(
        .NUM_EVENTS     (3),
        .HALF_PERIOD_W  (20),
        .HALF_PERIODS   ({20'd10, 20'd6, 20'd4}),
        .DURATION_CYCLES(32'd40),
        .AMPLITUDE      (32'd1000),
        .DECAY_SHIFT    (DS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .trigger (trigger),
        .mute    (mute),
        .out     (out),
        .busy    (busy),
        .active  (active)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: a burst is (event, start edge, end edge, amplitude).
    int   halves[3] = '{4, 6, 10};
    int   m_n = 0, m_sel = 0, m_t0 = 0, m_end = 0, m_amp = AMP;
    bit   m_play = 0;
    logic [2:0] m_prev = 3'b000;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            m_prev = 3'b000;
            m_play = 0;
            m_sel  = 0;
            m_amp  = AMP;
        end else begin
            logic [2:0] r;
            int w;
            m_n++;
            r = trigger & ~m_prev;
            m_prev = trigger;
            w = -1;
            for (int i = 2; i >= 0; i--) if (r[i]) w = i;
            if (w >= 0 && (!m_play || w < m_sel)) begin
                m_play = 1; m_sel = w; m_t0 = m_n; m_end = m_n + DUR; m_amp = AMP;
            end else if (m_play && r[m_sel]) begin
                m_end = m_n + DUR; m_amp = AMP;
            end else if (m_play) begin
`ifdef TONE_DECAY_EN
                if ((m_n - m_t0) % (2 * halves[m_sel]) == 0) m_amp = m_amp - (m_amp >> DS);
`endif
            end
            if (m_n >= m_end) m_play = 0;
        end
    end

    always @(negedge CLOCK_50) begin
        int eo;
        int ea;
        eo = 0;
        if (m_play && !mute)
            eo = (((m_n - m_t0) / halves[m_sel]) % 2 == 0) ? m_amp : -m_amp;
        ea = m_play ? (1 << m_sel) : 0;
        chk("model_out", out, eo);
        chk("model_busy", int'(busy), int'(m_play));
        chk("model_active", int'(active), ea);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #3;
    endtask

    int peak;

    initial begin
`ifdef TONE_DECAY_EN
        peak = 938;
`else
        peak = 1000;
`endif
        reset = 1'b1; trigger = 3'b000; mute = 1'b0;
        #1;
        chk("reset_out", out, 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_active", int'(active), 0);
        tick(2); reset = 1'b0; tick(2);

        // Basic burst on event 1 (half = 6)
        trigger = 3'b010; tick(1); trigger = 3'b000;
        chk("basic_first", out, 1000);
        chk("basic_active", int'(active), 2);
        tick(5);  chk("basic_k5", out, 1000);
        tick(1);  chk("basic_k6", out, -1000);
        tick(6);  chk("basic_k12_peak", out, peak);
        tick(27); chk("basic_k39_busy", int'(busy), 1);
        tick(1);  chk("basic_k40_busy", int'(busy), 0);
        chk("basic_k40_out", out, 0);
        tick(3);

        // Preempt event 2 by event 0; a later event-2 edge is ignored
        trigger = 3'b100; tick(1); trigger = 3'b000;
        chk("pre_ev2_active", int'(active), 4);
        tick(4); trigger = 3'b001; tick(1); trigger = 3'b000;
        chk("pre_ev0_active", int'(active), 1);
        chk("pre_ev0_out", out, 1000);
        tick(4); chk("pre_k9_out", out, -1000);
        trigger = 3'b100; tick(1); trigger = 3'b000;
        chk("pre_ignore_active", int'(active), 1);
        tick(34); chk("pre_k44_busy", int'(busy), 1);
        tick(1);  chk("pre_k45_busy", int'(busy), 0);
        tick(3);

        // Retrigger on the last cycle of the burst
        trigger = 3'b010; tick(1); trigger = 3'b000;
        tick(38); trigger = 3'b010; tick(1); trigger = 3'b000;
        chk("rt_k39_busy", int'(busy), 1);
        tick(3);  chk("rt_k42_out", out, -1000);
        tick(36); chk("rt_k78_busy", int'(busy), 1);
        tick(1);  chk("rt_k79_busy", int'(busy), 0);
        tick(3);

        // Simultaneous rises, then held high
        trigger = 3'b110; tick(1);
        chk("sim_active", int'(active), 2);
        tick(39); chk("sim_k39_busy", int'(busy), 1);
        tick(1);  chk("sim_k40_busy", int'(busy), 0);
        trigger = 3'b000; tick(3);

        // Mute mid-burst
        trigger = 3'b001; tick(1); trigger = 3'b000;
        tick(10); mute = 1'b1; #1;
        chk("mute_out", out, 0);
        chk("mute_busy", int'(busy), 1);
        tick(29); chk("mute_k39_busy", int'(busy), 1);
        mute = 1'b0;
        tick(1);  chk("mute_k40_busy", int'(busy), 0);
        tick(2);

        // Async reset mid-burst, trigger held through release
        trigger = 3'b001; tick(1); trigger = 3'b000;
        tick(5); reset = 1'b1; #1;
        chk("arst_out", out, 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_active", int'(active), 0);
        trigger = 3'b100;
        tick(2); reset = 1'b0;
        tick(1); chk("held_rel_active", int'(active), 4);
        chk("held_rel_out", out, 1000);
        tick(40); chk("held_end_busy", int'(busy), 0);
        trigger = 3'b000; tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
